// File: rtl/pico_sequencer_if.sv
// rtl/pico_sequencer_if.sv - picoMips opcodes and sequencer-to-core signal bundle
package pico_opcodes_pkg;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_MULI = 3'd3;
    localparam logic [2:0] OP_LSW  = 3'd4;
    localparam logic [2:0] OP_ATR  = 3'd5;
    localparam logic [2:0] OP_HEI  = 3'd6;
    localparam logic [2:0] OP_RTA  = 3'd7;
endpackage

interface pico_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              Run;
    logic [2:0]        Func;
    logic              HeiArg;
    logic              Sw8;
    logic [ADDR_W-1:0] InstrAddr;
    logic              FetchEn;
    logic              AccWe;
    logic              RegWe;
    logic [1:0]        Phase;
    logic              Waiting;
    logic              Idle;

    modport master (
        input  Run, Func, HeiArg, Sw8,
        output InstrAddr, FetchEn, AccWe, RegWe, Phase, Waiting, Idle
    );

    modport slave (
        output Run, Func, HeiArg, Sw8,
        input  InstrAddr, FetchEn, AccWe, RegWe, Phase, Waiting, Idle
    );
endinterface

// File: rtl/pico_sequencer.sv
// rtl/pico_sequencer.sv - four-phase FETCH/DECODE/READ/EXEC sequencer with OP_HEI stall on debounced SW[8]
module pico_sequencer
    import pico_opcodes_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int LAST_ADDR = 23,
    parameter int DEBOUNCE  = 4
) (
    input logic               Clock,
    input logic               Reset,
    pico_sequencer_if.master  bus
);

    localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] instr_addr, addr_nxt, addr_inc;
    logic              sw8_s1, sw8_s2, sw8_db;
    logic [CNT_W-1:0]  db_cnt;

    logic              fetch_en, acc_we, reg_we, waiting, idle;
    logic [1:0]        phase;
    logic              hei_stall;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            instr_addr <= '0;
        end else begin
            state      <= state_nxt;
            instr_addr <= addr_nxt;
        end
    end

    // sw8_db only flips after DEBOUNCE back-to-back synchronised samples disagree with it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sw8_s1 <= 1'b0;
            sw8_s2 <= 1'b0;
            sw8_db <= 1'b0;
            db_cnt <= '0;
        end else begin
            sw8_s1 <= bus.Sw8;
            sw8_s2 <= sw8_s1;
            if (sw8_s2 == sw8_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE - 1)) begin
                sw8_db <= sw8_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign addr_inc  = (instr_addr == ADDR_W'(LAST_ADDR)) ? '0 : instr_addr + ADDR_W'(1);
    assign hei_stall = (sw8_db == bus.HeiArg);

    always_comb begin
        state_nxt = state;
        addr_nxt  = instr_addr;
        fetch_en  = 1'b0;
        acc_we    = 1'b0;
        reg_we    = 1'b0;
        waiting   = 1'b0;
        idle      = 1'b0;
        phase     = 2'd0;
        case (state)
            S_IDLE: begin
                idle = 1'b1;
                if (bus.Run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                fetch_en  = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                phase     = 2'd1;
                state_nxt = S_READ;
            end
            S_READ: begin
                phase     = 2'd2;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                phase = 2'd3;
                if (bus.Func == OP_HEI && hei_stall) begin
                    state_nxt = S_WAIT;
                end else begin
                    acc_we    = (bus.Func != OP_HEI) && (bus.Func != OP_ATR);
                    reg_we    = (bus.Func == OP_ATR);
                    addr_nxt  = addr_inc;
                    state_nxt = bus.Run ? S_FETCH : S_IDLE;
                end
            end
            S_WAIT: begin
                phase   = 2'd3;
                waiting = 1'b1;
                // Run is deliberately ignored until the switch releases the stall.
                if (!hei_stall) begin
                    addr_nxt  = addr_inc;
                    state_nxt = bus.Run ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Reset aborts the instruction in flight, so a strobe must not escape in that cycle.
    assign bus.AccWe     = acc_we & ~Reset;
    assign bus.RegWe     = reg_we & ~Reset;
    assign bus.FetchEn   = fetch_en;
    assign bus.Phase     = phase;
    assign bus.Waiting   = waiting;
    assign bus.Idle      = idle;
    assign bus.InstrAddr = instr_addr;

endmodule
